// File: rtl/q_6_6_beh.sv
// q_6_6_beh: WIDTH-bit register with synchronous parallel load and serial
// right shift. Serial data enters at the MSB and leaves at the LSB, so
// several instances can be chained SO -> SI to form a longer shift chain.
module q_6_6_beh #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] I,
    input  logic             SI,
    output logic             SO,
    output logic [WIDTH-1:0] A
);

    // Register update: reset, then shift (beats load), then load, else hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            A <= '0;
        end else if (shift) begin
            A <= {SI, A[WIDTH-1:1]};
        end else if (load) begin
            A <= I;
        end
    end

    // Serial output is taken straight from the register LSB, with no extra stage.
    assign SO = A[0];

endmodule

// File: tb/tb_q_6_6_beh.sv
// tb_q_6_6_beh: vector table and scoreboard bench for q_6_6_beh.
module tb_q_6_6_beh;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rstn;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] I;
    logic             SI;
    logic             SO;
    logic [WIDTH-1:0] A;

    typedef struct {
        string            name;
        logic             rstn;
        logic             load;
        logic             shift;
        logic [WIDTH-1:0] i;
        logic             si;
        logic [WIDTH-1:0] exp_a;
        logic             exp_so;
    } vec_t;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] exp_a;
        logic             exp_so;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] model_a;

    q_6_6_beh #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .load  (load),
        .shift (shift),
        .I     (I),
        .SI    (SI),
        .SO    (SO),
        .A     (A)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string name, input logic r, input logic l, input logic s,
                       input logic [WIDTH-1:0] i, input logic si,
                       input logic [WIDTH-1:0] ea, input logic eso);
        vec_t v;
        v.name = name; v.rstn = r; v.load = l; v.shift = s;
        v.i = i; v.si = si; v.exp_a = ea; v.exp_so = eso;
        vecs.push_back(v);
    endtask

    task automatic check_a(input string name, input logic [WIDTH-1:0] exp_a, input logic exp_so);
        checks++;
        if (A !== exp_a) begin
            errors++;
            $display("FAIL %s: A got %b want %b", name, A, exp_a);
        end
        checks++;
        if (SO !== exp_so) begin
            errors++;
            $display("FAIL %s: SO got %b want %b", name, SO, exp_so);
        end
    endtask

    // Drive on the falling edge, queue the expectation, then compare 1 time unit after the rising edge.
    task automatic step(input string name, input logic r, input logic l, input logic s,
                        input logic [WIDTH-1:0] i, input logic si,
                        input logic [WIDTH-1:0] ea, input logic eso);
        exp_t e;
        @(negedge clk);
        rstn = r; load = l; shift = s; I = i; SI = si;
        e.name = name; e.exp_a = ea; e.exp_so = eso;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty got A=%b want entry", name, A);
        end else begin
            e = sb.pop_front();
            check_a(e.name, e.exp_a, e.exp_so);
        end
    endtask

    initial begin
        rstn = 1'b1; load = 1'b0; shift = 1'b0; I = '0; SI = 1'b0;

        add("reset",        0, 0, 0, 4'b0000, 0, 4'b0000, 0);
        add("reset_rel",    1, 0, 0, 4'b0000, 0, 4'b0000, 0);
        add("load_1010",    1, 1, 0, 4'b1010, 1, 4'b1010, 0);
        add("hold_1",       1, 0, 0, 4'b0101, 1, 4'b1010, 0);
        add("hold_2",       1, 0, 0, 4'b1111, 0, 4'b1010, 0);
        add("hold_3",       1, 0, 0, 4'b0000, 1, 4'b1010, 0);
        add("shl_prio_1",   1, 1, 1, 4'b1111, 0, 4'b0101, 1);
        add("sh0_2",        1, 1, 1, 4'b1111, 0, 4'b0010, 0);
        add("sh0_3",        1, 1, 1, 4'b1111, 0, 4'b0001, 1);
        add("sh0_4",        1, 1, 1, 4'b1111, 0, 4'b0000, 0);
        add("sh0_5",        1, 1, 1, 4'b1111, 0, 4'b0000, 0);
        add("sh1_1",        1, 0, 1, 4'b0000, 1, 4'b1000, 0);
        add("sh1_2",        1, 0, 1, 4'b0000, 1, 4'b1100, 0);
        add("sh1_3",        1, 0, 1, 4'b0000, 1, 4'b1110, 0);
        add("sh1_4",        1, 0, 1, 4'b0000, 1, 4'b1111, 1);
        add("rst_prio_1",   0, 1, 1, 4'b1010, 1, 4'b0000, 0);
        add("rst_prio_2",   0, 1, 1, 4'b1010, 1, 4'b0000, 0);
        add("rst_prio_3",   0, 1, 0, 4'b0110, 1, 4'b0000, 0);
        add("recover_load", 1, 1, 0, 4'b1010, 0, 4'b1010, 0);
        add("recover_hold", 1, 0, 0, 4'b0011, 1, 4'b1010, 0);
        add("load_only_si", 1, 1, 0, 4'b0111, 1, 4'b0111, 1);
        add("shift_mid",    1, 0, 1, 4'b0000, 0, 4'b0011, 1);

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].name, vecs[k].rstn, vecs[k].load, vecs[k].shift,
                 vecs[k].i, vecs[k].si, vecs[k].exp_a, vecs[k].exp_so);
        end

        // Reset pulse between edges must not disturb A (A = 0011 here).
        @(negedge clk);
        load = 1'b0; shift = 1'b0;
        rstn = 1'b0;
        #2;
        check_a("glitch_mid", 4'b0011, 1'b1);
        rstn = 1'b1;
        step("glitch_after", 1, 0, 0, 4'b0000, 0, 4'b0011, 1);

        // Reset asserted mid-load discards the load.
        step("load_a", 1, 1, 0, 4'b1001, 0, 4'b1001, 1);
        step("rst_mid_load", 0, 1, 0, 4'b0110, 0, 4'b0000, 0);
        step("resume_shift", 1, 0, 1, 4'b0000, 1, 4'b1000, 0);

        // Randomised traffic against a behavioural model.
        model_a = 4'b1000;
        for (int n = 0; n < 60; n++) begin
            logic r, l, s, si;
            logic [WIDTH-1:0] iv;
            r  = ($urandom_range(0, 9) != 0);
            l  = $urandom_range(0, 1);
            s  = $urandom_range(0, 1);
            si = $urandom_range(0, 1);
            iv = WIDTH'($urandom);
            if (!r)      model_a = '0;
            else if (s)  model_a = {si, model_a[WIDTH-1:1]};
            else if (l)  model_a = iv;
            step($sformatf("rand_%0d", n), r, l, s, iv, si, model_a, model_a[0]);
        end

        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL sb_drain: got %0d leftover entries want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation got past 100000 time units want completion");
        $fatal(1);
    end

endmodule
